irq_prio_ctrl: RTL
==================

// Module: irq_prio_ctrl
// PURPOSE
//  Interrupt controller that collects N raw interrupt sources, latches them as pending, and presents one vector at a time.
//  Detection is per-source: edge or level. The winning vector is chosen by masked priority arbitration.
//  Its outputs drive the src side of an irq_if (same N, PRIO_W); the ack from the sink retires the presented vector.
//  Sits between device interrupt lines and the CPU-side interrupt sink.
// PARAMETERS
//  N       32  number of interrupt sources (>=1)
//  PRIO_W  2   priority field width per source (>=1); larger value = more urgent
//  VEC_W   derived localparam: (N<=1) ? 1 : $clog2(N)
// PORTS
//  clk             in   1         system clock
//  rst_n           in   1         reset, asynchronous assert, active-low
//  src_irq         in   N         raw sources, synchronous to clk, active-high
//  cfg_edge        in   N         1 = rising-edge triggered, 0 = level triggered
//  cfg_mask        in   N         1 = source enabled for presentation
//  cfg_prio        in   N*PRIO_W  priority of source i at [i*PRIO_W +: PRIO_W]
//  irq_valid       out  1         a vector is presented
//  irq_vector      out  VEC_W     presented source index
//  irq_prio        out  PRIO_W    priority of presented source
//  irq_pending     out  N         pending bitmap (unmasked), debug view
//  irq_ack         in   1         sink accepts presented vector
//  irq_ack_vector  in   VEC_W     vector being acknowledged
//  ack_err         out  1         1-cycle pulse: ack with !irq_valid or mismatched vector
// BEHAVIOUR
//  Reset: all state and all outputs 0; FSM enters IDLE.
//  Sampling: src_q <= src_irq each cycle; prev_q <= src_q for edge detect.
//  Pending, level mode: pend[i] <= src_q[i].
//  Pending, edge mode: pend[i] set on src_q & ~prev_q; cleared on accepted ack of vector i.
//    Set and clear of the same bit in one cycle: set wins.
//  Latency: src_irq high before edge k -> src_q at k -> pend at k+1 -> irq_valid at k+2 (if idle and winning).
//  Arbitration: over pend & cfg_mask; highest cfg_prio wins; tie -> lowest index.
//  FSM IDLE: a candidate exists -> register irq_vector/irq_prio, irq_valid<=1, go PRESENT.
//  FSM PRESENT: vector/prio held stable; no preemption by higher-priority arrivals.
//    Accepted ack (irq_ack && irq_ack_vector==irq_vector) -> clear edge pend bit, irq_valid<=0, go IDLE.
//    Withdraw: presented bit no longer pend&mask (level drop or mask clear) -> irq_valid<=0, go IDLE, no ack_err.
//    Withdraw and accepted ack in same cycle: ack taken; ack_err=0.
//  At least one IDLE cycle between presentations. A level source still high after ack is re-presented.
//  ack_err: registered pulse for irq_ack while irq_valid=0 or vector mismatch. Such acks change no state.
//  irq_pending = pend (registered, unmasked).
//  cfg_* are quasi-static; a change takes effect at the next arbitration or withdraw check.
//  Reset mid-presentation: async clear, irq_valid drops immediately; edge events in flight are lost.
// STRUCTURE
//  carbon_irq_pkg: irq_state_e {IRQ_IDLE, IRQ_PRESENT}; vec_w(N) function.
//  Sub-module irq_prio_arb: combinational N-way max-priority/lowest-index select.
//    Inputs: req[N], prio[N*PRIO_W]. Outputs: any, idx[VEC_W], prio[PRIO_W].
//  Top holds the sync/edge registers, pend, FSM, and output registers.
//  SVA (FORMAL/CARBON_ENABLE_SVA):
//    irq_vector and irq_prio stable while irq_valid && !accepted ack && !withdraw.
//    irq_valid implies pend[irq_vector].
// TESTING
//  1. Edge src 5, prio 1, mask on; 1-cycle pulse -> irq_valid=1, vector=5 two cycles later; ack 5 -> valid 0 next cycle, pending[5]=0.
//  2. Edge srcs 3 (prio 2) and 7 (prio 3) same cycle -> 7 first; after ack, IDLE 1 cycle, then 3.
//  3. Srcs 4 and 9 both prio 2 -> 4 presented first (tie -> lowest index).
//  4. Level src 2 held high across ack -> re-presented after 1 idle cycle. Drop src 2 while presented, no ack -> valid 0, ack_err 0.
//  5. Ack vector 6 while presenting 1 -> ack_err pulse, vector 1 stays valid; ack with valid=0 -> ack_err pulse.
//  6. Masked pending src 8 -> not presented, pending[8]=1; unmask -> presented. Assert rst_n low mid-PRESENT -> all outputs 0 at once.

Source files
------------

// File: rtl/irq_prio_ctrl_pkg.sv
// Shared types and helpers for the interrupt priority controller.
package carbon_irq_pkg;

    // Presentation FSM: idle, or holding one vector for the sink.
    typedef enum logic [0:0] {
        IrqIdle,
        IrqPresent
    } irq_state_e;

    // Width of a vector index for n sources; never narrower than one bit.
    function automatic int unsigned vec_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_ctrl_arb.sv
// Combinational N-way arbiter: highest priority wins, ties go to the lowest index.
module irq_prio_arb
    import carbon_irq_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned PRIO_W = 2,
    localparam int unsigned VEC_W = vec_w(N)
) (
    input  logic [N-1:0]        req,
    input  logic [N*PRIO_W-1:0] prio,
    output logic                any,
    output logic [VEC_W-1:0]    idx,
    output logic [PRIO_W-1:0]   win_prio
);

    // Ascending scan with strict '>' keeps the lowest index on equal priority.
    always_comb begin
        any      = 1'b0;
        idx      = '0;
        win_prio = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && (!any || (prio[i*PRIO_W +: PRIO_W] > win_prio))) begin
                any      = 1'b1;
                idx      = VEC_W'(i);
                win_prio = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt controller: samples raw sources, keeps a pending bitmap (edge or level per source)
// and presents one masked, priority-arbitrated vector at a time to the interrupt sink.
module irq_prio_ctrl
    import carbon_irq_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned PRIO_W = 2,
    localparam int unsigned VEC_W = vec_w(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        src_irq,
    input  logic [N-1:0]        cfg_edge,
    input  logic [N-1:0]        cfg_mask,
    input  logic [N*PRIO_W-1:0] cfg_prio,
    output logic                irq_valid,
    output logic [VEC_W-1:0]    irq_vector,
    output logic [PRIO_W-1:0]   irq_prio,
    output logic [N-1:0]        irq_pending,
    input  logic                irq_ack,
    input  logic [VEC_W-1:0]    irq_ack_vector,
    output logic                ack_err
);

    logic [N-1:0]      src_q, prev_q;
    logic [N-1:0]      pend_q, pend_d;
    irq_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [PRIO_W-1:0] prio_q, prio_d;
    logic              ack_err_q, ack_err_d;

    logic              arb_any;
    logic [VEC_W-1:0]  arb_idx;
    logic [PRIO_W-1:0] arb_prio;

    logic [N-1:0]      vec_onehot;
    logic              ack_ok;
    logic              withdraw;

    irq_prio_arb #(
        .N      (N),
        .PRIO_W (PRIO_W)
    ) u_arb (
        .req      (pend_q & cfg_mask),
        .prio     (cfg_prio),
        .any      (arb_any),
        .idx      (arb_idx),
        .win_prio (arb_prio)
    );

    // Decode the presented vector so pend bits can be tested/cleared without a variable index.
    always_comb begin
        vec_onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            vec_onehot[i] = (vec_q == VEC_W'(i));
        end
    end

    // Accepted ack and withdraw conditions, both only meaningful while presenting.
    always_comb begin
        ack_ok    = (state_q == IrqPresent) && irq_ack && (irq_ack_vector == vec_q);
        withdraw  = (state_q == IrqPresent) && ((pend_q & cfg_mask & vec_onehot) == '0);
        // Any ack that is not accepted is an error and changes no state.
        ack_err_d = irq_ack && !ack_ok;
    end

    // Pending update: level bits follow the sampled source; edge bits latch, set beats clear.
    always_comb begin
        logic [N-1:0] clr;
        clr    = ack_ok ? vec_onehot : '0;
        pend_d = (cfg_edge & ((src_q & ~prev_q) | (pend_q & ~clr)))
               | (~cfg_edge & src_q);
    end

    // Presentation FSM next-state; the held vector is never preempted.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        vec_d   = vec_q;
        prio_d  = prio_q;
        unique case (state_q)
            IrqIdle: begin
                if (arb_any) begin
                    state_d = IrqPresent;
                    valid_d = 1'b1;
                    vec_d   = arb_idx;
                    prio_d  = arb_prio;
                end
            end
            IrqPresent: begin
                if (ack_ok || withdraw) begin
                    state_d = IrqIdle;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            prev_q    <= '0;
            pend_q    <= '0;
            state_q   <= IrqIdle;
            valid_q   <= 1'b0;
            vec_q     <= '0;
            prio_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            src_q     <= src_irq;
            prev_q    <= src_q;
            pend_q    <= pend_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            vec_q     <= vec_d;
            prio_q    <= prio_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign irq_valid   = valid_q;
    assign irq_vector  = vec_q;
    assign irq_prio    = prio_q;
    assign irq_pending = pend_q;
    assign ack_err     = ack_err_q;

`ifdef CARBON_ENABLE_SVA
    // Presented vector/priority hold until the presentation ends.
    a_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (irq_valid && !ack_ok && !withdraw) |=> ($stable(irq_vector) && $stable(irq_prio)));

    // A presented vector was pending on the cycle that led to it being shown.
    a_pend: assert property (@(posedge clk) disable iff (!rst_n)
        irq_valid |-> (($past(pend_q) & vec_onehot) != '0));
`endif

endmodule
